// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master AHB-Lite SRAM arbiter.
// SRAM_AW is the address width carried in a captured request.
package sram_arb_pkg;

  localparam int SRAM_AW = 16;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DATA = 2'd2
  } mst_state_t;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [2:0]         size;
    logic               write;
  } req_t;

endpackage

// File: rtl/sram_arb_req_stage.sv
// Per-master address-phase capture register and IDLE/PEND/DATA state machine.
module sram_arb_req_stage
  import sram_arb_pkg::*;
#(
  parameter int AW = SRAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsel_i,
  input  logic          hready_i,
  input  logic [1:0]    htrans_i,
  input  logic [2:0]    hsize_i,
  input  logic          hwrite_i,
  input  logic [AW-1:0] haddr_i,
  input  logic          slv_rdy_i,
  input  logic          grant_i,
  output mst_state_t    state_o,
  output req_t          req_o
);

  mst_state_t state_q, state_d;
  req_t       req_q, req_d;
  logic       capture;
  logic       can_capture;

  assign capture = hsel_i & hready_i &
                   ((htrans_i == TRN_NONSEQ) | (htrans_i == TRN_SEQ));

  // An owner finishing its data phase may accept its next address phase.
  assign can_capture = (state_q == ST_IDLE) | ((state_q == ST_DATA) & slv_rdy_i);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: if (capture) state_d = ST_PEND;
      ST_PEND: if (slv_rdy_i && grant_i) state_d = ST_DATA;
      ST_DATA: if (slv_rdy_i) state_d = capture ? ST_PEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (capture && can_capture) begin
      req_d.addr  = SRAM_AW'(haddr_i);
      req_d.size  = hsize_i;
      req_d.write = hwrite_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign state_o = state_q;
  assign req_o   = req_q;

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single-port SRAM slave.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; default is fixed M0 priority.
module ahb_sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW = SRAM_AW
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          M0_HSEL,
  input  logic          M0_HREADY,
  input  logic [1:0]    M0_HTRANS,
  input  logic [2:0]    M0_HSIZE,
  input  logic          M0_HWRITE,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [31:0]   M0_HWDATA,
  output logic          M0_HREADYOUT,
  output logic          M0_HRESP,
  output logic [31:0]   M0_HRDATA,
  input  logic          M1_HSEL,
  input  logic          M1_HREADY,
  input  logic [1:0]    M1_HTRANS,
  input  logic [2:0]    M1_HSIZE,
  input  logic          M1_HWRITE,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [31:0]   M1_HWDATA,
  output logic          M1_HREADYOUT,
  output logic          M1_HRESP,
  output logic [31:0]   M1_HRDATA,
  output logic          S_HSEL,
  output logic [1:0]    S_HTRANS,
  output logic [2:0]    S_HSIZE,
  output logic          S_HWRITE,
  output logic [AW-1:0] S_HADDR,
  output logic          S_HREADY,
  output logic [31:0]   S_HWDATA,
  input  logic          S_HREADYOUT,
  input  logic          S_HRESP,
  input  logic [31:0]   S_HRDATA
);

  logic          m_hsel   [2];
  logic          m_hready [2];
  logic [1:0]    m_htrans [2];
  logic [2:0]    m_hsize  [2];
  logic          m_hwrite [2];
  logic [AW-1:0] m_haddr  [2];
  mst_state_t    st       [2];
  req_t          req      [2];
  logic [1:0]    pend;
  logic [1:0]    own;
  logic [1:0]    gnt_vec;
  logic [1:0]    hrdyout;

  owner_t owner_q, owner_d;
  owner_t gnt;
  logic   slv_rdy;
  logic   tie_m1;
  req_t   req_sel;

  assign m_hsel[0]   = M0_HSEL;
  assign m_hready[0] = M0_HREADY;
  assign m_htrans[0] = M0_HTRANS;
  assign m_hsize[0]  = M0_HSIZE;
  assign m_hwrite[0] = M0_HWRITE;
  assign m_haddr[0]  = M0_HADDR;
  assign m_hsel[1]   = M1_HSEL;
  assign m_hready[1] = M1_HREADY;
  assign m_htrans[1] = M1_HTRANS;
  assign m_hsize[1]  = M1_HSIZE;
  assign m_hwrite[1] = M1_HWRITE;
  assign m_haddr[1]  = M1_HADDR;

  assign slv_rdy    = (owner_q == OWN_NONE) | S_HREADYOUT;
  assign gnt_vec[0] = (gnt == OWN_M0);
  assign gnt_vec[1] = (gnt == OWN_M1);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mst
      sram_arb_req_stage #(.AW(AW)) u_req (
        .clk       (HCLK),
        .rst       (HRESET),
        .hsel_i    (m_hsel[gi]),
        .hready_i  (m_hready[gi]),
        .htrans_i  (m_htrans[gi]),
        .hsize_i   (m_hsize[gi]),
        .hwrite_i  (m_hwrite[gi]),
        .haddr_i   (m_haddr[gi]),
        .slv_rdy_i (slv_rdy),
        .grant_i   (gnt_vec[gi]),
        .state_o   (st[gi]),
        .req_o     (req[gi])
      );
      assign pend[gi]    = (st[gi] == ST_PEND);
      assign own[gi]     = (owner_q == ((gi == 0) ? OWN_M0 : OWN_M1));
      assign hrdyout[gi] = (st[gi] == ST_PEND) ? 1'b0 :
                           (st[gi] == ST_DATA) ? S_HREADYOUT : 1'b1;
    end
  endgenerate

`ifdef SRAM_ARB_RR_EN
  // last_grant_q: 1 = M1 was granted most recently.
  logic last_grant_q;

  assign tie_m1 = ~last_grant_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      last_grant_q <= 1'b1;
    end else if (gnt == OWN_M0) begin
      last_grant_q <= 1'b0;
    end else if (gnt == OWN_M1) begin
      last_grant_q <= 1'b1;
    end
  end
`else
  assign tie_m1 = 1'b0;
`endif

  always_comb begin
    gnt = OWN_NONE;
    if (slv_rdy) begin
      if (pend[0] && pend[1]) gnt = tie_m1 ? OWN_M1 : OWN_M0;
      else if (pend[0])       gnt = OWN_M0;
      else if (pend[1])       gnt = OWN_M1;
    end
  end

  assign owner_d = slv_rdy ? gnt : owner_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign req_sel  = gnt_vec[1] ? req[1] : req[0];
  assign S_HSEL   = (gnt != OWN_NONE);
  assign S_HTRANS = S_HSEL ? TRN_NONSEQ : TRN_IDLE;
  assign S_HADDR  = S_HSEL ? AW'(req_sel.addr) : '0;
  assign S_HSIZE  = S_HSEL ? req_sel.size : 3'd0;
  assign S_HWRITE = S_HSEL & req_sel.write;
  assign S_HREADY = slv_rdy;

  always_comb begin
    case (owner_q)
      OWN_M0:  S_HWDATA = M0_HWDATA;
      OWN_M1:  S_HWDATA = M1_HWDATA;
      default: S_HWDATA = 32'h0;
    endcase
  end

  assign M0_HREADYOUT = hrdyout[0];
  assign M1_HREADYOUT = hrdyout[1];
  assign M0_HRESP     = own[0] & S_HRESP;
  assign M1_HRESP     = own[1] & S_HRESP;
  assign M0_HRDATA    = own[0] ? S_HRDATA : 32'h0;
  assign M1_HRDATA    = own[1] ? S_HRDATA : 32'h0;

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Directed bench for ahb_sram_arbiter with a behavioural zero-wait SRAM slave
// (wait states and error responses injectable). Honours SRAM_ARB_RR_EN.
`timescale 1ns/1ps
module tb_ahb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 16;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_hsel, m0_hready, m0_hwrite, m0_hreadyout, m0_hresp;
  logic [1:0]    m0_htrans;
  logic [2:0]    m0_hsize;
  logic [AW-1:0] m0_haddr;
  logic [31:0]   m0_hwdata, m0_hrdata;
  logic          m1_hsel, m1_hready, m1_hwrite, m1_hreadyout, m1_hresp;
  logic [1:0]    m1_htrans;
  logic [2:0]    m1_hsize;
  logic [AW-1:0] m1_haddr;
  logic [31:0]   m1_hwdata, m1_hrdata;
  logic          s_hsel, s_hwrite, s_hready, s_hreadyout, s_hresp;
  logic [1:0]    s_htrans;
  logic [2:0]    s_hsize;
  logic [AW-1:0] s_haddr;
  logic [31:0]   s_hwdata, s_hrdata;

  logic s_wait = 1'b0;
  logic s_err  = 1'b0;

  int checks = 0;
  int errors = 0;

  assign m0_hready = m0_hreadyout;
  assign m1_hready = m1_hreadyout;

  ahb_sram_arbiter #(.AW(AW)) dut (
    .HCLK(clk), .HRESET(rst),
    .M0_HSEL(m0_hsel), .M0_HREADY(m0_hready), .M0_HTRANS(m0_htrans), .M0_HSIZE(m0_hsize),
    .M0_HWRITE(m0_hwrite), .M0_HADDR(m0_haddr), .M0_HWDATA(m0_hwdata),
    .M0_HREADYOUT(m0_hreadyout), .M0_HRESP(m0_hresp), .M0_HRDATA(m0_hrdata),
    .M1_HSEL(m1_hsel), .M1_HREADY(m1_hready), .M1_HTRANS(m1_htrans), .M1_HSIZE(m1_hsize),
    .M1_HWRITE(m1_hwrite), .M1_HADDR(m1_haddr), .M1_HWDATA(m1_hwdata),
    .M1_HREADYOUT(m1_hreadyout), .M1_HRESP(m1_hresp), .M1_HRDATA(m1_hrdata),
    .S_HSEL(s_hsel), .S_HTRANS(s_htrans), .S_HSIZE(s_hsize), .S_HWRITE(s_hwrite),
    .S_HADDR(s_haddr), .S_HREADY(s_hready), .S_HWDATA(s_hwdata),
    .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp), .S_HRDATA(s_hrdata)
  );

  // SRAM slave model: word array preset to 0xA5A5_0000 | word index on reset.
  logic [31:0] mem [0:1023];
  logic        dp_valid, dp_write;
  logic [9:0]  dp_idx;

  assign s_hreadyout = !(dp_valid && s_wait);
  assign s_hresp     = dp_valid && s_err;
  assign s_hrdata    = (dp_valid && !dp_write) ? mem[dp_idx] : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (s_hready) begin
      if (dp_valid && dp_write) mem[dp_idx] <= s_hwdata;
      dp_valid <= s_hsel && s_htrans[1];
      dp_write <= s_hwrite;
      dp_idx   <= s_haddr[11:2];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m0_req(input logic [1:0] trn, input logic wr, input logic [AW-1:0] a);
    m0_hsel = (trn != TRN_IDLE); m0_htrans = trn; m0_hwrite = wr; m0_haddr = a;
  endtask

  task automatic m1_req(input logic [1:0] trn, input logic wr, input logic [AW-1:0] a);
    m1_hsel = (trn != TRN_IDLE); m1_htrans = trn; m1_hwrite = wr; m1_haddr = a;
  endtask

  logic [AW-1:0] first_addr, second_addr, exp_addr;
  logic [31:0]   first_rdata;
  int            m0_done, all_done;

  initial begin
    m0_req(TRN_IDLE, 1'b0, '0); m1_req(TRN_IDLE, 1'b0, '0);
    m0_hsize = 3'b010; m1_hsize = 3'b010;
    m0_hwdata = 32'h0; m1_hwdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_rdy", m0_hreadyout, 1'b1);
    chk("rst_m1_rdy", m1_hreadyout, 1'b1);
    chk("rst_s_hready", s_hready, 1'b1);
    chk("rst_s_hsel", s_hsel, 1'b0);
    chk("rst_s_htrans", s_htrans, TRN_IDLE);
    chk("rst_s_haddr", s_haddr, 0);
    chk("rst_s_hwdata", s_hwdata, 0);
    chk("rst_m0_rdata", m0_hrdata, 0);
    rst = 1'b0;

    // Simultaneous NONSEQ: M0 read 0x100, M1 write 0x200
    @(negedge clk); m0_req(TRN_NONSEQ, 1'b0, 16'h0100); m1_req(TRN_NONSEQ, 1'b1, 16'h0200); #1;
    chk("sim_t_m0_rdy", m0_hreadyout, 1'b1);
    @(negedge clk); m0_req(TRN_IDLE, 1'b0, '0); m1_req(TRN_IDLE, 1'b0, '0); m1_hwdata = 32'h1234_5678; #1;
    chk("sim_t1_s_hsel", s_hsel, 1'b1);
    chk("sim_t1_s_htrans", s_htrans, TRN_NONSEQ);
    chk("sim_t1_s_haddr", s_haddr, 16'h0100);
    chk("sim_t1_m0_rdy", m0_hreadyout, 1'b0);
    chk("sim_t1_m1_rdy", m1_hreadyout, 1'b0);
    @(negedge clk); #1;
    chk("sim_t2_m0_rdy", m0_hreadyout, 1'b1);
    chk("sim_t2_m0_rdata", m0_hrdata, 32'hA5A5_0040);
    chk("sim_t2_s_hsel", s_hsel, 1'b1);
    chk("sim_t2_s_haddr", s_haddr, 16'h0200);
    chk("sim_t2_s_hwrite", s_hwrite, 1'b1);
    chk("sim_t2_m1_rdy", m1_hreadyout, 1'b0);
    @(negedge clk); #1;
    chk("sim_t3_m1_rdy", m1_hreadyout, 1'b1);
    chk("sim_t3_s_hwdata", s_hwdata, 32'h1234_5678);
    chk("sim_t3_s_hsel", s_hsel, 1'b0);

    // M0 write 0x10 <= DEADBEEF, then read back with a back-to-back capture
    @(negedge clk); m0_req(TRN_NONSEQ, 1'b1, 16'h0010); #1;
    chk("wr_t_m0_rdy", m0_hreadyout, 1'b1);
    @(negedge clk); m0_req(TRN_IDLE, 1'b0, '0); m0_hwdata = 32'hDEAD_BEEF; #1;
    chk("wr_t1_m0_rdy", m0_hreadyout, 1'b0);
    chk("wr_t1_s_haddr", s_haddr, 16'h0010);
    chk("wr_t1_s_hwrite", s_hwrite, 1'b1);
    chk("wr_t1_m1_rdy", m1_hreadyout, 1'b1);
    @(negedge clk); m0_req(TRN_NONSEQ, 1'b0, 16'h0010); #1;
    chk("wr_t2_m0_rdy", m0_hreadyout, 1'b1);
    chk("wr_t2_s_hwdata", s_hwdata, 32'hDEAD_BEEF);
    chk("wr_t2_s_hsel", s_hsel, 1'b0);
    @(negedge clk); m0_req(TRN_IDLE, 1'b0, '0); #1;
    chk("rd_t1_m0_rdy", m0_hreadyout, 1'b0);
    chk("rd_t1_s_haddr", s_haddr, 16'h0010);
    chk("rd_t1_s_hwrite", s_hwrite, 1'b0);
    chk("rd_t1_m1_rdy", m1_hreadyout, 1'b1);
    @(negedge clk); #1;
    chk("rd_t2_m0_rdy", m0_hreadyout, 1'b1);
    chk("rd_t2_m0_rdata", m0_hrdata, 32'hDEAD_BEEF);
    chk("rd_t2_m1_rdata", m1_hrdata, 32'h0);

    // Tie after M0 was granted last: fixed -> M0 first, round-robin -> M1 first
    first_addr  = RR ? 16'h0200 : 16'h0010;
    second_addr = RR ? 16'h0010 : 16'h0200;
    first_rdata = RR ? 32'h1234_5678 : 32'hDEAD_BEEF;
    @(negedge clk); m0_req(TRN_NONSEQ, 1'b0, 16'h0010); m1_req(TRN_NONSEQ, 1'b0, 16'h0200); #1;
    @(negedge clk); m0_req(TRN_IDLE, 1'b0, '0); m1_req(TRN_IDLE, 1'b0, '0); #1;
    chk("tie_t1_s_haddr", s_haddr, first_addr);
    @(negedge clk); #1;
    chk("tie_t2_s_haddr", s_haddr, second_addr);
    chk("tie_t2_rdata", RR ? m1_hrdata : m0_hrdata, first_rdata);
    @(negedge clk); #1;
    chk("tie_t3_both_rdy", {m0_hreadyout, m1_hreadyout}, 2'b11);

    // Back-to-back reads from both masters for 20 cycles
    first_addr  = RR ? 16'h0304 : 16'h0300;
    second_addr = RR ? 16'h0300 : 16'h0304;
    m0_done = 0; all_done = 0;
    @(negedge clk); m0_req(TRN_NONSEQ, 1'b0, 16'h0300); m1_req(TRN_NONSEQ, 1'b0, 16'h0304); #1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      exp_addr = (k % 2 == 1) ? first_addr : second_addr;
      chk($sformatf("strm_c%0d_s_hsel", k), s_hsel, 1'b1);
      chk($sformatf("strm_c%0d_s_haddr", k), s_haddr, exp_addr);
      m0_done  += int'(m0_hreadyout);
      all_done += int'(m0_hreadyout) + int'(m1_hreadyout);
      if (k == 20) begin
        m0_req(TRN_IDLE, 1'b0, '0); m1_req(TRN_IDLE, 1'b0, '0);
      end
    end
    chk("strm_m0_done", m0_done, RR ? 9 : 10);
    chk("strm_all_done", all_done, 19);
    repeat (2) @(negedge clk);
    #1;
    chk("strm_drain_rdy", {m0_hreadyout, m1_hreadyout}, 2'b11);
    chk("strm_drain_s_hsel", s_hsel, 1'b0);

    // Slave wait states during M0 data phase with M1 pending
    @(negedge clk); m0_req(TRN_NONSEQ, 1'b0, 16'h0010); #1;
    @(negedge clk); m0_req(TRN_IDLE, 1'b0, '0); m1_req(TRN_NONSEQ, 1'b0, 16'h0200); #1;
    chk("ws_t1_s_haddr", s_haddr, 16'h0010);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk); m1_req(TRN_IDLE, 1'b0, '0); s_wait = 1'b1; #1;
      chk($sformatf("ws_w%0d_m0_rdy", w), m0_hreadyout, 1'b0);
      chk($sformatf("ws_w%0d_m1_rdy", w), m1_hreadyout, 1'b0);
      chk($sformatf("ws_w%0d_s_hsel", w), s_hsel, 1'b0);
      chk($sformatf("ws_w%0d_s_haddr", w), s_haddr, 16'h0000);
      chk($sformatf("ws_w%0d_s_hready", w), s_hready, 1'b0);
    end
    @(negedge clk); s_wait = 1'b0; #1;
    chk("ws_rel_m0_rdy", m0_hreadyout, 1'b1);
    chk("ws_rel_m0_rdata", m0_hrdata, 32'hDEAD_BEEF);
    chk("ws_rel_s_hsel", s_hsel, 1'b1);
    chk("ws_rel_s_haddr", s_haddr, 16'h0200);
    @(negedge clk); #1;
    chk("ws_m1_rdy", m1_hreadyout, 1'b1);
    chk("ws_m1_rdata", m1_hrdata, 32'h1234_5678);

    // Two-cycle ERROR response passes through to M0 only
    @(negedge clk); m0_req(TRN_NONSEQ, 1'b0, 16'h0010); #1;
    @(negedge clk); m0_req(TRN_IDLE, 1'b0, '0); #1;
    @(negedge clk); s_wait = 1'b1; s_err = 1'b1; #1;
    chk("err_c1_m0_resp", m0_hresp, 1'b1);
    chk("err_c1_m0_rdy", m0_hreadyout, 1'b0);
    chk("err_c1_m1_resp", m1_hresp, 1'b0);
    @(negedge clk); s_wait = 1'b0; #1;
    chk("err_c2_m0_resp", m0_hresp, 1'b1);
    chk("err_c2_m0_rdy", m0_hreadyout, 1'b1);
    @(negedge clk); s_err = 1'b0; #1;
    chk("err_done_m0_resp", m0_hresp, 1'b0);

    // Asynchronous reset while M1 is in its (waited) data phase
    @(negedge clk); m1_req(TRN_NONSEQ, 1'b0, 16'h0200); #1;
    @(negedge clk); m1_req(TRN_IDLE, 1'b0, '0); #1;
    chk("ar_t1_s_haddr", s_haddr, 16'h0200);
    @(negedge clk); s_wait = 1'b1; #1;
    chk("ar_pre_m1_rdy", m1_hreadyout, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_m1_rdy", m1_hreadyout, 1'b1);
    chk("ar_m0_rdy", m0_hreadyout, 1'b1);
    chk("ar_s_hsel", s_hsel, 1'b0);
    chk("ar_s_hready", s_hready, 1'b1);
    chk("ar_m1_rdata", m1_hrdata, 32'h0);
    s_wait = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); m1_req(TRN_NONSEQ, 1'b0, 16'h0200); #1;
    chk("ar_post_t_m1_rdy", m1_hreadyout, 1'b1);
    @(negedge clk); m1_req(TRN_IDLE, 1'b0, '0); #1;
    chk("ar_post_t1_m1_rdy", m1_hreadyout, 1'b0);
    chk("ar_post_t1_s_haddr", s_haddr, 16'h0200);
    @(negedge clk); #1;
    chk("ar_post_t2_m1_rdy", m1_hreadyout, 1'b1);
    chk("ar_post_t2_m1_rdata", m1_hrdata, 32'hA5A5_0080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
